// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU types: RV32M operation codes, multiply/divide FSM
//             states and iteration count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

    function automatic logic op_is_mul(input muldiv_op_t op);
        return ~op[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
//  Module   : muldiv_signfix
//  Purpose  : Conditional two's-complement negate of a WIDTH-bit value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_signfix #(
    parameter int WIDTH = 64
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle RV32M multiply/divide unit (shift-add multiply,
//             restoring divide). Define MULDIV_EARLY_OUT_EN for 1-cycle
//             completion of divide-by-zero, signed overflow and zero multiply.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  muldiv_op_t        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(MULDIV_ITERS - 1);

    muldiv_state_t       r_state_q, w_state_d;
    logic [CNT_W-1:0]    r_cnt_q, w_cnt_d;
    muldiv_op_t          r_op_q, w_op_d;
    logic [DATA_W-1:0]   r_a_q, w_a_d;
    logic [DATA_W-1:0]   r_b_q, w_b_d;
    logic                r_neg_q, w_neg_d;
    logic [2*DATA_W-1:0] r_acc_q, w_acc_d;
    logic [DATA_W-1:0]   r_res_q, w_res_d;
    logic                r_req_ready_q, r_resp_valid_q, r_busy_q;

    // Request-side operand conditioning
    logic              w_a_sgn, w_b_sgn;
    logic [DATA_W-1:0] w_a_abs, w_b_abs;
    logic              w_req_neg;

    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        case (req_op)
            MULH, DIV, REM: begin
                w_a_sgn = req_a[DATA_W-1];
                w_b_sgn = req_b[DATA_W-1];
            end
            MULHSU:  w_a_sgn = req_a[DATA_W-1];
            default: ;
        endcase
        w_a_abs = w_a_sgn ? ((~req_a) + DATA_W'(1)) : req_a;
        w_b_abs = w_b_sgn ? ((~req_b) + DATA_W'(1)) : req_b;
        // A zero divisor must leave the all-ones quotient untouched.
        if (req_op inside {REM, REMU})
            w_req_neg = w_a_sgn;
        else
            w_req_neg = (w_a_sgn ^ w_b_sgn) && (req_b != '0);
    end

    // One iteration: multiply keeps multiplier in the low half and shifts the
    // partial product in from the top; divide keeps {remainder, quotient}.
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W-1:0]   w_div_sub;
    logic                w_div_ge;
    logic [2*DATA_W-1:0] w_acc_step;

    always_comb begin
        w_mul_sum   = {1'b0, r_acc_q[2*DATA_W-1:DATA_W]} + {1'b0, r_a_q};
        w_div_shift = r_acc_q[2*DATA_W-1:DATA_W-1];
        w_div_sub   = w_div_shift[DATA_W-1:0] - r_b_q;
        w_div_ge    = w_div_shift[DATA_W] || (w_div_shift[DATA_W-1:0] >= r_b_q);
        if (op_is_mul(r_op_q))
            w_acc_step = r_acc_q[0] ? {w_mul_sum, r_acc_q[DATA_W-1:1]}
                                    : {1'b0, r_acc_q[2*DATA_W-1:1]};
        else
            w_acc_step = w_div_ge ? {w_div_sub, r_acc_q[DATA_W-2:0], 1'b1}
                                  : {r_acc_q[2*DATA_W-2:0], 1'b0};
    end

    logic [2*DATA_W-1:0] w_fix_in, w_fix_out;
    logic [DATA_W-1:0]   w_final;

    always_comb begin
        case (r_op_q)
            REM, REMU: w_fix_in = {{DATA_W{1'b0}}, w_acc_step[2*DATA_W-1:DATA_W]};
            DIV, DIVU: w_fix_in = {{DATA_W{1'b0}}, w_acc_step[DATA_W-1:0]};
            default:   w_fix_in = w_acc_step;
        endcase
        if (r_op_q inside {MULH, MULHSU, MULHU})
            w_final = w_fix_out[2*DATA_W-1:DATA_W];
        else
            w_final = w_fix_out[DATA_W-1:0];
    end

    muldiv_signfix #(
        .WIDTH (2*DATA_W)
    ) u_signfix (
        .i_neg (r_neg_q),
        .i_val (w_fix_in),
        .o_val (w_fix_out)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic              w_early;
    logic [DATA_W-1:0] w_early_res;

    always_comb begin
        w_early     = 1'b0;
        w_early_res = '0;
        if (op_is_mul(req_op)) begin
            w_early = (req_a == '0) || (req_b == '0);
        end else if (req_b == '0) begin
            w_early     = 1'b1;
            w_early_res = (req_op inside {REM, REMU}) ? req_a : '1;
        end else if ((req_op inside {DIV, REM}) && (req_b == '1) &&
                     (req_a == {1'b1, {(DATA_W-1){1'b0}}})) begin
            w_early     = 1'b1;
            w_early_res = (req_op == DIV) ? req_a : '0;
        end
    end
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_op_d    = r_op_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_neg_d   = r_neg_q;
        w_acc_d   = r_acc_q;
        w_res_d   = r_res_q;
        if (flush) begin
            w_state_d = IDLE;
        end else begin
            case (r_state_q)
                IDLE: if (req_valid) begin
                    w_state_d = BUSY;
                    w_cnt_d   = '0;
                    w_op_d    = req_op;
                    w_a_d     = w_a_abs;
                    w_b_d     = w_b_abs;
                    w_neg_d   = w_req_neg;
                    w_acc_d   = {{DATA_W{1'b0}}, op_is_mul(req_op) ? w_b_abs : w_a_abs};
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_early) begin
                        w_state_d = DONE;
                        w_res_d   = w_early_res;
                    end
`endif
                end
                BUSY: begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                    w_acc_d = w_acc_step;
                    if (r_cnt_q == c_last_cnt) begin
                        w_state_d = DONE;
                        w_res_d   = w_final;
                    end
                end
                DONE:    if (resp_ready) w_state_d = IDLE;
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q      <= IDLE;
            r_cnt_q        <= '0;
            r_op_q         <= MUL;
            r_a_q          <= '0;
            r_b_q          <= '0;
            r_neg_q        <= 1'b0;
            r_acc_q        <= '0;
            r_res_q        <= '0;
            r_req_ready_q  <= 1'b1;
            r_resp_valid_q <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_op_q         <= w_op_d;
            r_a_q          <= w_a_d;
            r_b_q          <= w_b_d;
            r_neg_q        <= w_neg_d;
            r_acc_q        <= w_acc_d;
            r_res_q        <= w_res_d;
            r_req_ready_q  <= (w_state_d == IDLE);
            r_resp_valid_q <= (w_state_d == DONE);
            r_busy_q       <= (w_state_d != IDLE);
        end
    end

    assign req_ready  = r_req_ready_q;
    assign resp_valid = r_resp_valid_q;
    assign busy       = r_busy_q;
    assign resp_out   = r_res_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit: transaction-level model,
//             directed literal cases and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import cpu_types_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, flush, req_valid, resp_ready;
    logic        req_ready, resp_valid, busy;
    muldiv_op_t  req_op;
    logic [31:0] req_a, req_b, resp_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.DATA_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result computed with plain wide arithmetic
    function automatic logic [31:0] ref_fn(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            MUL:    begin p = ua * ub; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        bit c;
        if (op inside {MUL, MULH, MULHSU, MULHU}) c = (a == 0) || (b == 0);
        else c = (b == 0) || ((op inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return EARLY && c;
    endfunction

    // Transaction model: 0 = idle, 1 = computing, 2 = result offered
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_out  = '0;

    always @(posedge CLK) begin
        if (RST) begin
            m_mode = 0;
            m_out  = '0;
        end else if (flush) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (req_valid) begin
                    m_res = ref_fn(req_op, req_a, req_b);
                    if (is_early(req_op, req_a, req_b)) begin
                        m_mode = 2;
                        m_out  = m_res;
                    end else begin
                        m_mode = 1;
                        m_left = 32;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_out  = m_res;
                    end
                end
                default: if (resp_ready) m_mode = 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("req_ready",  {31'b0, req_ready},  {31'b0, m_mode == 0});
            check("resp_valid", {31'b0, resp_valid}, {31'b0, m_mode == 2});
            check("busy",       {31'b0, busy},       {31'b0, m_mode != 0});
            check("resp_out",   resp_out, m_out);
        end
    end

    task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int cyc;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        @(negedge CLK);
        req_valid = 1'b0;
        cyc = 1;
        if (lat > 1) check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        while (resp_valid !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check($sformatf("latency_%s", op.name()), cyc, lat);
        check($sformatf("result_%s", op.name()), resp_out, exp);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        int lat_special;
        RST = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        req_op = MUL; req_a = '0; req_b = '0;
        lat_special = EARLY ? 1 : 33;
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_resp_out",   resp_out,            32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        do_op(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op(MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        do_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        do_op(DIVU,   32'd100,        32'd7,         32'd14,        33);
        do_op(REMU,   32'd100,        32'd7,         32'd2,         33);
        do_op(DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, lat_special);
        do_op(REM,    32'd5,          32'd0,         32'd5,         lat_special);
        do_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, lat_special);
        do_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         lat_special);
        do_op(MUL,    32'd0,          32'h1234_5678, 32'd0,         lat_special);

        // Backpressure in DONE
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = DIVU; req_a = 32'd100; req_b = 32'd7;
        @(negedge CLK);
        req_valid = 1'b0;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check("bp_latency", cyc, 33);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = MUL; req_a = $urandom; req_b = $urandom;
            check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_resp_out",   resp_out,            32'd14);
            @(negedge CLK);
        end
        resp_ready = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        check("bp_release_ready", {31'b0, req_ready}, 32'd1);
        check("bp_release_busy",  {31'b0, busy},      32'd0);
        @(negedge CLK);

        // Flush mid-operation
        req_valid = 1'b1; req_op = MUL; req_a = 32'd7; req_b = 32'd3;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy",      {31'b0, busy},      32'd0);
        check("flush_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (40) begin
            check("flush_no_resp", {31'b0, resp_valid}, 32'd0);
            @(negedge CLK);
        end

        // Reset mid-operation
        req_valid = 1'b1; req_op = DIV; req_a = 32'd77; req_b = 32'd5;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rstmid_busy",     {31'b0, busy}, 32'd0);
        check("rstmid_resp_out", resp_out,      32'd0);
        repeat (40) begin
            check("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
            @(negedge CLK);
        end
        do_op(MULHU, 32'd3, 32'd5, 32'd0, 33);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_op     = muldiv_op_t'($urandom_range(0, 7));
            req_a      = rnd_opnd();
            req_b      = rnd_opnd();
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            RST        = ($urandom_range(0, 199) == 0);
            @(negedge CLK);
        end
        req_valid = 1'b0; flush = 1'b0; RST = 1'b0; resp_ready = 1'b1;
        repeat (3) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
